// File: rtl/tick_agendador_if.sv
// Request/acknowledge handshake between the tick scheduler and the sonar measurement block.
// master = scheduler (drives req), slave = measurement block (drives ack).
interface tick_agendador_if;
    logic req;
    logic ack;

    modport master (output req, input ack);
    modport slave  (input req, output ack);
endinterface

// File: rtl/tick_agendador.sv
// Counts tick pulses and issues a measurement request over req/ack every INTERVALO ticks,
// with a tick-counted timeout. Optional macro TICK_BORDA_EN adds a tick synchronizer + edge detector.
module tick_agendador #(
    parameter int INTERVALO     = 2,
    parameter int TIMEOUT_TICKS = 3,
    parameter int W             = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  tick,
    tick_agendador_if.master      bus,
    output logic                  ocupado,
    output logic                  erro,
    output logic [W-1:0]          n_pedidos
);

    localparam int MAXV = (INTERVALO > TIMEOUT_TICKS) ? INTERVALO : TIMEOUT_TICKS;
    localparam int CW   = $clog2(MAXV + 1);
    localparam logic [CW-1:0] LIM_ESPERA = CW'(INTERVALO);
    localparam logic [CW-1:0] LIM_PEDIDO = CW'(TIMEOUT_TICKS);

    typedef enum logic [1:0] {
        PARADO,
        ESPERA,
        PEDIDO
    } estado_t;

    estado_t       estado;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          tick_evt;

    assign cnt_inc = cnt + CW'(1);

`ifdef TICK_BORDA_EN
    logic sync_a;
    logic sync_b;
    logic sync_prev;

    // Two-flop synchronizer, then one event per rising edge regardless of pulse width.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_a    <= 1'b0;
            sync_b    <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync_a    <= tick;
            sync_b    <= sync_a;
            sync_prev <= sync_b;
        end
    end

    assign tick_evt = sync_b & ~sync_prev;
`else
    assign tick_evt = tick;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado    <= PARADO;
            cnt       <= '0;
            bus.req   <= 1'b0;
            ocupado   <= 1'b0;
            erro      <= 1'b0;
            n_pedidos <= '0;
        end else if (!enable) begin
            // erro and n_pedidos stay visible while stopped; they clear on re-enable.
            estado  <= PARADO;
            cnt     <= '0;
            bus.req <= 1'b0;
            ocupado <= 1'b0;
        end else begin
            case (estado)
                PARADO: begin
                    estado    <= ESPERA;
                    cnt       <= '0;
                    erro      <= 1'b0;
                    n_pedidos <= '0;
                end
                ESPERA: begin
                    if (tick_evt) begin
                        if (cnt_inc == LIM_ESPERA) begin
                            estado  <= PEDIDO;
                            cnt     <= '0;
                            bus.req <= 1'b1;
                            ocupado <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end
                PEDIDO: begin
                    // ack takes priority over a simultaneous tick, so it never times out.
                    if (bus.ack) begin
                        estado    <= ESPERA;
                        cnt       <= '0;
                        bus.req   <= 1'b0;
                        ocupado   <= 1'b0;
                        n_pedidos <= n_pedidos + W'(1);
                    end else if (tick_evt) begin
                        if (cnt_inc == LIM_PEDIDO) begin
                            estado  <= ESPERA;
                            cnt     <= '0;
                            bus.req <= 1'b0;
                            ocupado <= 1'b0;
                            erro    <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end
                default: begin
                    estado  <= PARADO;
                    cnt     <= '0;
                    bus.req <= 1'b0;
                    ocupado <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tick_agendador.sv
// Self-checking bench for tick_agendador: cycle table plus hand-written corner sequences,
// with a scoreboard that checks the outcome of every completed request.
module tb_tick_agendador;

    localparam int W = 2;

    logic         clock;
    logic         reset;
    logic         enable;
    logic         tick;
    logic         ocupado;
    logic         erro;
    logic [W-1:0] n_pedidos;

    tick_agendador_if bus ();

    tick_agendador #(
        .INTERVALO     (2),
        .TIMEOUT_TICKS (3),
        .W             (W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .tick      (tick),
        .bus       (bus.master),
        .ocupado   (ocupado),
        .erro      (erro),
        .n_pedidos (n_pedidos)
    );

    typedef struct {
        logic         tick;
        logic         ack;
        logic         enable;
        logic         req;
        logic         ocupado;
        logic         erro;
        logic [W-1:0] n;
    } vec_t;

    typedef struct {
        logic         erro;
        logic [W-1:0] n;
    } exp_t;

    int   checks;
    int   errors;
    exp_t sb[$];
    logic abort_ok;
    logic [W-1:0] n_model;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
    endtask

    task automatic wait_req(input string name);
        int k;
        for (k = 0; k < 20 && bus.req !== 1'b1; k++) step();
        check({name, " req within budget"}, {31'd0, bus.req}, 32'd1);
    endtask

    function automatic vec_t mk(input logic t, input logic a, input logic e, input logic r,
                                input logic o, input logic er, input logic [W-1:0] n);
        vec_t v;
        v.tick = t; v.ack = a; v.enable = e;
        v.req = r; v.ocupado = o; v.erro = er; v.n = n;
        return v;
    endfunction

    // Scoreboard: every request that ends (req falls) pops the expected outcome.
    initial begin
        logic prev_req;
        exp_t e;
        prev_req = 1'b0;
        forever begin
            @(posedge clock);
            #2;
            if (prev_req === 1'b1 && bus.req === 1'b0) begin
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("sb erro", {31'd0, erro}, {31'd0, e.erro});
                    check("sb n_pedidos", {30'd0, n_pedidos}, {30'd0, e.n});
                end else if (!abort_ok) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL sb unexpected req drop: got 0, expected 1");
                end
            end
            prev_req = bus.req;
        end
    end

    task automatic applyStimulus();
        vec_t tbl[$];
        logic prev_exp_req;
        exp_t e;

        //             tick ack en  req oc erro n
        tbl.push_back(mk(0, 0, 0,  0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1,  0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1,  0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1,  0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1,  1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1,  1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1,  0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 1,  0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 1,  0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 1,  1, 1, 0, 1));
        tbl.push_back(mk(1, 0, 1,  1, 1, 0, 1));
        tbl.push_back(mk(1, 0, 1,  1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1,  1, 1, 0, 1));
        tbl.push_back(mk(1, 0, 1,  0, 0, 1, 1));
        tbl.push_back(mk(1, 0, 1,  0, 0, 1, 1));
        tbl.push_back(mk(1, 0, 1,  1, 1, 1, 1));
        tbl.push_back(mk(1, 1, 1,  0, 0, 1, 2));
        tbl.push_back(mk(1, 0, 1,  0, 0, 1, 2));
        tbl.push_back(mk(1, 0, 1,  1, 1, 1, 2));
        tbl.push_back(mk(0, 0, 0,  0, 0, 1, 2));
        tbl.push_back(mk(1, 0, 0,  0, 0, 1, 2));
        tbl.push_back(mk(0, 0, 1,  0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1,  0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1,  1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1,  0, 0, 0, 1));

        prev_exp_req = 1'b0;
        for (int i = 0; i < tbl.size(); i++) begin
            tick    = tbl[i].tick;
            bus.ack = tbl[i].ack;
            enable  = tbl[i].enable;
            if (!tbl[i].enable) abort_ok = 1'b1;
            if (tbl[i].enable && prev_exp_req && !tbl[i].req) begin
                e.erro = tbl[i].erro;
                e.n    = tbl[i].n;
                sb.push_back(e);
            end
            step();
            check($sformatf("row%0d req", i),     {31'd0, bus.req}, {31'd0, tbl[i].req});
            check($sformatf("row%0d ocupado", i), {31'd0, ocupado}, {31'd0, tbl[i].ocupado});
            check($sformatf("row%0d erro", i),    {31'd0, erro},    {31'd0, tbl[i].erro});
            check($sformatf("row%0d n", i),       {30'd0, n_pedidos}, {30'd0, tbl[i].n});
            prev_exp_req = tbl[i].req;
        end
        tick    = 1'b0;
        bus.ack = 1'b0;
        step();
        abort_ok = 1'b0;
    endtask

    task automatic checkOutput();
        exp_t e;

        // Clear counters, then four acked requests must wrap n_pedidos 1,2,3,0.
        enable = 1'b0;
        step();
        enable = 1'b1;
        step();
        check("reenable erro", {31'd0, erro}, 32'd0);
        check("reenable n", {30'd0, n_pedidos}, 32'd0);
        n_model = '0;
        for (int r = 0; r < 4; r++) begin
            pulse_tick();
            pulse_tick();
            wait_req($sformatf("wrap%0d", r));
            n_model = n_model + W'(1);
            bus.ack = 1'b1;
            e.erro  = 1'b0;
            e.n     = n_model;
            sb.push_back(e);
            step();
            bus.ack = 1'b0;
            check($sformatf("wrap%0d n", r), {30'd0, n_pedidos}, {30'd0, n_model});
            check($sformatf("wrap%0d req low", r), {31'd0, bus.req}, 32'd0);
        end

`ifdef TICK_BORDA_EN
        // A 5-cycle-wide tick counts once, two cycles after its rise.
        tick = 1'b1;
        for (int c = 0; c < 5; c++) step();
        tick = 1'b0;
        for (int c = 0; c < 4; c++) step();
        check("wide1 req", {31'd0, bus.req}, 32'd0);
        tick = 1'b1;
        step();
        check("wide2 req +1", {31'd0, bus.req}, 32'd0);
        step();
        check("wide2 req +2", {31'd0, bus.req}, 32'd0);
        step();
        check("wide2 req +3", {31'd0, bus.req}, 32'd1);
        step();
        step();
        tick = 1'b0;
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < 3; c++) step();
            tick = 1'b1;
            for (int c = 0; c < 5; c++) step();
            tick = 1'b0;
        end
        for (int c = 0; c < 4; c++) step();
        check("wide pedido still req", {31'd0, bus.req}, 32'd1);
        check("wide pedido erro", {31'd0, erro}, 32'd0);
        bus.ack = 1'b1;
        e.erro  = 1'b0;
        e.n     = n_model + W'(1);
        sb.push_back(e);
        step();
        bus.ack = 1'b0;
`endif

        // Reset during PEDIDO must drop req without a clock edge.
        pulse_tick();
        pulse_tick();
        wait_req("async");
        abort_ok = 1'b1;
        #3;
        reset = 1'b0;
        #1;
        check("async req", {31'd0, bus.req}, 32'd0);
        check("async ocupado", {31'd0, ocupado}, 32'd0);
        check("async n", {30'd0, n_pedidos}, 32'd0);
        step();
        reset = 1'b1;
        step();
        step();
        abort_ok = 1'b0;
        check("sb drained", sb.size(), 32'd0);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        abort_ok = 1'b0;
        reset    = 1'b0;
        enable   = 1'b0;
        tick     = 1'b0;
        bus.ack  = 1'b0;
        #12;
        check("reset req", {31'd0, bus.req}, 32'd0);
        check("reset ocupado", {31'd0, ocupado}, 32'd0);
        check("reset erro", {31'd0, erro}, 32'd0);
        check("reset n", {30'd0, n_pedidos}, 32'd0);
        step();
        reset = 1'b1;
        step();
`ifndef TICK_BORDA_EN
        applyStimulus();
`endif
        checkOutput();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
